// File: rtl/zx_kbd_pkg.sv
// zx_kbd_pkg: virtual-key indices, scancode lookup and key-to-matrix map
package zx_kbd_pkg;
  localparam int VK_COUNT = 48;
  localparam int VK_CS = 0;
  localparam int VK_SS = 36;
  localparam int VK_RSHIFT = 40;
  localparam int VK_BKSP = 41;
  localparam int VK_LEFT = 42;
  localparam int VK_DOWN = 43;
  localparam int VK_UP = 44;
  localparam int VK_RIGHT = 45;
  localparam int VK_ALT = 46;
  localparam int VK_DEL = 47;
  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_PAUSE = 8'hE1;
  typedef enum logic [2:0] {ST_IDLE, ST_BRK, ST_EXT, ST_EXT_BRK, ST_SKIP} dec_state_t;
  typedef struct packed {
    logic pv;
    logic [2:0] pr;
    logic [2:0] pc;
    logic sv;
    logic [2:0] sr;
    logic [2:0] sc;
  } vk_map_t;
  typedef struct packed {
    logic hit;
    logic [5:0] idx;
  } vk_hit_t;
  // Indices 0..39 follow matrix order (row*5 + col); left Ctrl doubles as SYMBOL SHIFT
  localparam logic [7:0] VK_CODE [VK_COUNT] = '{
    8'h12, 8'h1A, 8'h22, 8'h21, 8'h2A,
    8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34,
    8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C,
    8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E,
    8'h45, 8'h46, 8'h3E, 8'h3D, 8'h36,
    8'h4D, 8'h44, 8'h43, 8'h3C, 8'h35,
    8'h5A, 8'h4B, 8'h42, 8'h3B, 8'h33,
    8'h29, 8'h14, 8'h3A, 8'h31, 8'h32,
    8'h59, 8'h66, 8'h6B, 8'h72, 8'h75, 8'h74, 8'h11, 8'h71
  };
  localparam logic [VK_COUNT-1:0] VK_EXT = 48'hBC00_0000_0000;
  function automatic vk_hit_t vk_lookup(input logic [7:0] code, input logic ext);
    vk_hit_t h = '0;
    for (int i = 0; i < VK_COUNT; i++)
      if (VK_CODE[i] == code && VK_EXT[i] == ext) h = '{hit: 1'b1, idx: 6'(i)};
    return h;
  endfunction
  function automatic vk_map_t vk_map(input int i);
    vk_map_t m = '0;
    m.pv = i != VK_ALT && i != VK_DEL;
    m.pr = i < 40 ? 3'(i / 5) : 3'd0;
    m.pc = i < 40 ? 3'(i % 5) : 3'd0;
    case (i)
      VK_BKSP: {m.sv, m.sr, m.sc} = {1'b1, 3'd4, 3'd0};
      VK_LEFT: {m.sv, m.sr, m.sc} = {1'b1, 3'd3, 3'd4};
      VK_DOWN: {m.sv, m.sr, m.sc} = {1'b1, 3'd4, 3'd4};
      VK_UP: {m.sv, m.sr, m.sc} = {1'b1, 3'd4, 3'd3};
      VK_RIGHT: {m.sv, m.sr, m.sc} = {1'b1, 3'd4, 3'd2};
      default: ;
    endcase
    return m;
  endfunction
endpackage

// File: rtl/ps2_rx.sv
// ps2_rx: PS/2 line synchronisers, clock filter and 11-bit frame receiver
module ps2_rx #(
  parameter int FILTER_LEN = 4,
  parameter int TIMEOUT_CYCLES = 14000
) (
  input logic clk14,
  input logic rst_n,
  input logic ps2_clk,
  input logic ps2_dat,
  output logic rx_valid,
  output logic [7:0] rx_byte,
  output logic frame_err
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [1:0] clk_sync, dat_sync;
  logic filt, flip, strobe, frame_ok, timeout, last_bit;
  logic [FW-1:0] filt_cnt;
  logic [TW-1:0] to_cnt;
  logic [3:0] bit_cnt;
  logic [9:0] shift;
  assign flip = clk_sync[1] != filt && filt_cnt == FW'(FILTER_LEN - 1);
  assign strobe = flip && filt;
  assign last_bit = bit_cnt == 4'd10;
  // shift holds start at [0], data at [8:1], parity at [9]; the stop bit is the live sample
  assign frame_ok = !shift[0] && dat_sync[1] && ^shift[9:1];
  assign timeout = !strobe && to_cnt == TW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk14 or negedge rst_n)
    if (!rst_n) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      filt <= 1'b1;
      filt_cnt <= '0;
      to_cnt <= '0;
      bit_cnt <= '0;
      shift <= '0;
      rx_valid <= 1'b0;
      rx_byte <= '0;
      frame_err <= 1'b0;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_dat};
      filt_cnt <= (clk_sync[1] == filt || flip) ? '0 : filt_cnt + 1'b1;
      filt <= flip ? ~filt : filt;
      to_cnt <= strobe ? '0 : (to_cnt == TW'(TIMEOUT_CYCLES) ? to_cnt : to_cnt + 1'b1);
      rx_valid <= strobe && last_bit && frame_ok;
      frame_err <= (strobe && last_bit && !frame_ok) || (timeout && bit_cnt != 4'd0);
      if (strobe) begin
        shift <= {dat_sync[1], shift[9:1]};
        bit_cnt <= last_bit ? 4'd0 : bit_cnt + 4'd1;
        if (last_bit) rx_byte <= shift[8:1];
      end else if (timeout) bit_cnt <= 4'd0;
    end
endmodule

// File: rtl/ps2_key_matrix.sv
// ps2_key_matrix: PS/2 set-2 decoder driving the ZX Spectrum 8x5 key matrix
module ps2_key_matrix
  import zx_kbd_pkg::*;
#(
  parameter int FILTER_LEN = 4,
  parameter int TIMEOUT_CYCLES = 14000
) (
  input logic clk14,
  input logic rst_n,
  input logic ps2_clk,
  input logic ps2_dat,
  input logic [7:0] addr_hi,
  output logic [4:0] kd,
  output logic key_reset,
  output logic frame_err
);
  logic rx_valid, combo, combo_q;
  logic [7:0] rx_byte;
  dec_state_t state;
  logic [2:0] skip_cnt;
  logic [VK_COUNT-1:0] flags;
  logic [7:0][4:0] mat;
  vk_hit_t hit;
  vk_map_t m;
  ps2_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
    .clk14(clk14),
    .rst_n(rst_n),
    .ps2_clk(ps2_clk),
    .ps2_dat(ps2_dat),
    .rx_valid(rx_valid),
    .rx_byte(rx_byte),
    .frame_err(frame_err)
  );
  assign hit = vk_lookup(rx_byte, state == ST_EXT || state == ST_EXT_BRK);
  assign combo = flags[VK_SS] & flags[VK_ALT] & flags[VK_DEL];
  always_ff @(posedge clk14 or negedge rst_n)
    if (!rst_n) begin
      state <= ST_IDLE;
      skip_cnt <= '0;
      flags <= '0;
      combo_q <= 1'b0;
      key_reset <= 1'b0;
    end else begin
      combo_q <= combo;
      key_reset <= combo & ~combo_q;
      if (rx_valid)
        case (state)
          ST_IDLE:
            if (rx_byte == PS2_BREAK) state <= ST_BRK;
            else if (rx_byte == PS2_EXT) state <= ST_EXT;
            else if (rx_byte == PS2_PAUSE) begin
              state <= ST_SKIP;
              skip_cnt <= 3'd7;
            end else if (rx_byte == 8'h00 || rx_byte == 8'hFF) flags <= '0;
            else if (hit.hit) flags[hit.idx] <= 1'b1;
          ST_EXT: begin
            state <= rx_byte == PS2_BREAK ? ST_EXT_BRK : ST_IDLE;
            if (rx_byte != PS2_BREAK && hit.hit) flags[hit.idx] <= 1'b1;
          end
          ST_BRK, ST_EXT_BRK: begin
            state <= ST_IDLE;
            if (hit.hit) flags[hit.idx] <= 1'b0;
          end
          default: begin
            skip_cnt <= skip_cnt - 3'd1;
            state <= skip_cnt == 3'd1 ? ST_IDLE : ST_SKIP;
          end
        endcase
    end
  // Each matrix bit is the OR of every held key that drives it
  always_comb begin
    mat = '0;
    m = '0;
    for (int i = 0; i < VK_COUNT; i++) begin
      m = vk_map(i);
      if (flags[i] && m.pv) mat[m.pr][m.pc] = 1'b1;
      if (flags[i] && m.sv) mat[m.sr][m.sc] = 1'b1;
    end
  end
  always_comb begin
    kd = '1;
    for (int c = 0; c < 5; c++)
      for (int r = 0; r < 8; r++)
        if (mat[r][c] && !addr_hi[r]) kd[c] = 1'b0;
  end
endmodule

// File: tb/tb_ps2_key_matrix.sv
// tb_ps2_key_matrix: self-checking bench for the PS/2 keyboard matrix
module tb_ps2_key_matrix;
  localparam int H = 12;
  logic clk14 = 1'b0, rst_n = 1'b0, ps2_clk = 1'b1, ps2_dat = 1'b1;
  logic [7:0] addr_hi = 8'hFF;
  logic [4:0] kd;
  logic key_reset, frame_err;
  int tests = 0, fails = 0, ferr_cnt = 0, kr_cnt = 0;
  bit held [512];
  typedef struct {
    logic [63:0] b;
    int n;
    logic [7:0] a;
    logic [4:0] e;
    string nm;
  } vec_t;
  vec_t vecs [26];
  logic [8:0] rnd_codes [19] = '{9'h012, 9'h059, 9'h014, 9'h066, 9'h01C, 9'h029, 9'h045,
    9'h03D, 9'h05A, 9'h032, 9'h01A, 9'h04D, 9'h011, 9'h00D, 9'h175, 9'h16B, 9'h172,
    9'h174, 9'h171};

  ps2_key_matrix dut (
    .clk14(clk14),
    .rst_n(rst_n),
    .ps2_clk(ps2_clk),
    .ps2_dat(ps2_dat),
    .addr_hi(addr_hi),
    .kd(kd),
    .key_reset(key_reset),
    .frame_err(frame_err)
  );

  always #5 clk14 = ~clk14;

  always @(negedge clk14) begin
    if (frame_err) ferr_cnt++;
    if (key_reset) kr_cnt++;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Key positions as {row, col} nibbles, straight from the Spectrum row listing
  function automatic void key_pos(input logic [8:0] k, output logic [7:0] p1, output logic [7:0] p2);
    p1 = 8'hFF;
    p2 = 8'hFF;
    case (k)
      9'h012, 9'h059: p1 = 8'h00;
      9'h01A: p1 = 8'h01; 9'h022: p1 = 8'h02; 9'h021: p1 = 8'h03; 9'h02A: p1 = 8'h04;
      9'h01C: p1 = 8'h10; 9'h01B: p1 = 8'h11; 9'h023: p1 = 8'h12; 9'h02B: p1 = 8'h13; 9'h034: p1 = 8'h14;
      9'h015: p1 = 8'h20; 9'h01D: p1 = 8'h21; 9'h024: p1 = 8'h22; 9'h02D: p1 = 8'h23; 9'h02C: p1 = 8'h24;
      9'h016: p1 = 8'h30; 9'h01E: p1 = 8'h31; 9'h026: p1 = 8'h32; 9'h025: p1 = 8'h33; 9'h02E: p1 = 8'h34;
      9'h045: p1 = 8'h40; 9'h046: p1 = 8'h41; 9'h03E: p1 = 8'h42; 9'h03D: p1 = 8'h43; 9'h036: p1 = 8'h44;
      9'h04D: p1 = 8'h50; 9'h044: p1 = 8'h51; 9'h043: p1 = 8'h52; 9'h03C: p1 = 8'h53; 9'h035: p1 = 8'h54;
      9'h05A: p1 = 8'h60; 9'h04B: p1 = 8'h61; 9'h042: p1 = 8'h62; 9'h03B: p1 = 8'h63; 9'h033: p1 = 8'h64;
      9'h029: p1 = 8'h70; 9'h014: p1 = 8'h71; 9'h03A: p1 = 8'h72; 9'h031: p1 = 8'h73; 9'h032: p1 = 8'h74;
      9'h066: begin p1 = 8'h00; p2 = 8'h40; end
      9'h16B: begin p1 = 8'h00; p2 = 8'h34; end
      9'h172: begin p1 = 8'h00; p2 = 8'h44; end
      9'h175: begin p1 = 8'h00; p2 = 8'h43; end
      9'h174: begin p1 = 8'h00; p2 = 8'h42; end
      default: ;
    endcase
  endfunction

  function automatic logic [4:0] model_kd(input logic [7:0] a);
    logic [4:0] k = '1;
    logic [7:0] p1, p2;
    for (int i = 0; i < 512; i++)
      if (held[i]) begin
        key_pos(9'(i), p1, p2);
        if (p1 != 8'hFF && !a[p1[6:4]]) k[p1[2:0]] = 1'b0;
        if (p2 != 8'hFF && !a[p2[6:4]]) k[p2[2:0]] = 1'b0;
      end
    return k;
  endfunction

  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk14);
      ps2_dat = f[i];
      repeat (H) @(negedge clk14);
      ps2_clk = 1'b0;
      repeat (H) @(negedge clk14);
      ps2_clk = 1'b1;
    end
    repeat (H) @(negedge clk14);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad = 1'b0);
    send_bits({1'b1, (~^b) ^ bad, b, 1'b0}, 11);
  endtask

  task automatic send_key(input logic [8:0] k, input bit brk);
    if (k[8]) send_byte(8'hE0);
    if (brk) send_byte(8'hF0);
    send_byte(k[7:0]);
    held[k] = !brk;
  endtask

  task automatic check_kd(input string name, input logic [7:0] a, input logic [4:0] e);
    @(negedge clk14);
    addr_hi = a;
    #1;
    check(name, kd, e);
  endtask

  initial begin
    int f0, k0;
    vecs = '{
      '{64'h1C, 1, 8'hFD, 5'h1E, "a_make"},
      '{64'h0, 0, 8'hFE, 5'h1F, "a_other_row"},
      '{64'h0, 0, 8'hFF, 5'h1F, "a_no_row"},
      '{64'hF01C, 2, 8'hFD, 5'h1F, "a_break"},
      '{64'h12, 1, 8'hFE, 5'h1E, "lshift"},
      '{64'h66, 1, 8'hFE, 5'h1E, "bksp_cs"},
      '{64'h0, 0, 8'hEF, 5'h1E, "bksp_zero"},
      '{64'hF066, 2, 8'hFE, 5'h1E, "cs_kept"},
      '{64'h0, 0, 8'hEF, 5'h1F, "bksp_rel"},
      '{64'h59, 1, 8'hFE, 5'h1E, "rshift"},
      '{64'hF012, 2, 8'hFE, 5'h1E, "lshift_rel"},
      '{64'hF059, 2, 8'hFE, 5'h1F, "rshift_rel"},
      '{64'hE075, 2, 8'h00, 5'h16, "up"},
      '{64'hE0F075, 3, 8'h00, 5'h1F, "up_rel"},
      '{64'hE06B, 2, 8'hF7, 5'h0F, "left_row3"},
      '{64'hE0F06B, 3, 8'h00, 5'h1F, "left_rel"},
      '{64'h29, 1, 8'h7F, 5'h1E, "space"},
      '{64'h00, 1, 8'h7F, 5'h1F, "clear_all"},
      '{64'hE11477E1F014F077, 8, 8'h7F, 5'h1F, "pause_skip"},
      '{64'h14, 1, 8'h7F, 5'h1D, "ctrl_ss"},
      '{64'hF014, 2, 8'h7F, 5'h1F, "ctrl_rel"},
      '{64'hAAFAFE, 3, 8'h00, 5'h1F, "ignored"},
      '{64'hE01C, 2, 8'hFD, 5'h1F, "ext_unknown"},
      '{64'h1C, 1, 8'hFD, 5'h1E, "a_again"},
      '{64'hFF, 1, 8'hFD, 5'h1F, "clear_ff"},
      '{64'h1C, 1, 8'hFE, 5'h1F, "a_row0"}
    };
    addr_hi = 8'h00;
    #1;
    check("reset_kd", kd, 5'h1F);
    check("reset_frame_err", frame_err, 1'b0);
    check("reset_key_reset", key_reset, 1'b0);
    repeat (5) @(negedge clk14);
    rst_n = 1'b1;
    check_kd("post_reset_kd", 8'h00, 5'h1F);
    for (int i = 0; i < 26; i++) begin
      for (int j = 0; j < vecs[i].n; j++) send_byte(vecs[i].b[8 * (vecs[i].n - 1 - j) +: 8]);
      check_kd(vecs[i].nm, vecs[i].a, vecs[i].e);
    end
    send_byte(8'hF0);
    send_byte(8'h1C);
    check_kd("table_end_clear", 8'h00, 5'h1F);
    f0 = ferr_cnt;
    check("no_err_on_good", f0, 0);
    send_byte(8'h1C, 1'b1);
    check("parity_err", ferr_cnt - f0, 1);
    check_kd("parity_kd", 8'hFD, 5'h1F);
    f0 = ferr_cnt;
    send_bits(11'b110_0101_0010, 5);
    repeat (14100) @(negedge clk14);
    check("timeout_err", ferr_cnt - f0, 1);
    send_key(9'h029, 1'b0);
    check_kd("after_timeout_space", 8'h7F, 5'h1E);
    send_key(9'h029, 1'b1);
    check("no_extra_err", ferr_cnt - f0, 1);
    k0 = kr_cnt;
    send_key(9'h014, 1'b0);
    send_key(9'h011, 1'b0);
    check("cad_early", kr_cnt - k0, 0);
    send_key(9'h171, 1'b0);
    check("cad_pulse", kr_cnt - k0, 1);
    send_key(9'h171, 1'b0);
    check("cad_repeat", kr_cnt - k0, 1);
    send_key(9'h171, 1'b1);
    send_key(9'h171, 1'b0);
    check("cad_rearm", kr_cnt - k0, 2);
    send_key(9'h014, 1'b1);
    send_key(9'h011, 1'b1);
    send_key(9'h171, 1'b1);
    check_kd("cad_released", 8'h00, 5'h1F);
    send_key(9'h01C, 1'b0);
    check_kd("hold_a", 8'hFD, 5'h1E);
    send_bits(11'b110_0101_0010, 5);
    @(negedge clk14);
    rst_n = 1'b0;
    #1;
    check("rst_mid_kd", kd, 5'h1F);
    check("rst_mid_err", frame_err, 1'b0);
    foreach (held[i]) held[i] = 1'b0;
    repeat (3) @(negedge clk14);
    rst_n = 1'b1;
    send_key(9'h01C, 1'b0);
    check_kd("after_rst_a", 8'hFD, 5'h1E);
    send_key(9'h01C, 1'b1);
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        send_byte(8'h00);
        foreach (held[j]) held[j] = 1'b0;
      end else send_key(rnd_codes[$urandom_range(0, 18)], 1'($urandom_range(0, 1)));
      begin
        logic [7:0] a;
        a = 8'($urandom);
        check_kd($sformatf("rand_%0d", i), a, model_kd(a));
      end
    end
    check_kd("rand_all_rows", 8'h00, model_kd(8'h00));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
